// File: rtl/crack_pkg.sv
// Shared types and display constants for the crack-core search controller.
package crack_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCrst,
        StLaunch,
        StRun,
        StDone,
        StFail
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/crack_ctrl_if.sv
// Controller <-> crack-core bundle: shared core reset, launch pulses and per-core results.
interface crack_ctrl_if #(
    parameter int unsigned NCORES = 2,
    parameter int unsigned KEY_W  = 24
);
    logic                      core_rst_n;
    logic [NCORES-1:0]         core_en;
    logic [NCORES-1:0]         core_rdy;
    logic [NCORES*KEY_W-1:0]   core_key;
    logic [NCORES-1:0]         core_key_valid;

    modport master (
        output core_rst_n,
        output core_en,
        input  core_rdy,
        input  core_key,
        input  core_key_valid
    );

    modport slave (
        input  core_rst_n,
        input  core_en,
        output core_rdy,
        output core_key,
        output core_key_valid
    );
endinterface

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module hex7seg
    import crack_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
        endcase
    end

endmodule

// File: rtl/crack_ctrl.sv
// Search controller: resets and launches NCORES crack cores, picks the first
// (lowest-index on ties) core reporting a valid key, and shows it on 7-seg digits.
module crack_ctrl
    import crack_pkg::*;
#(
    parameter int unsigned NCORES = 2,
    parameter int unsigned KEY_W  = 24,
    parameter int unsigned NDIG   = KEY_W / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    crack_ctrl_if.master      cores,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [KEY_W-1:0]  key,
    output logic [31:0]       cycles,
    output logic [7*NDIG-1:0] seg
);

    state_e              st_q, st_d;
    logic                kill_q, kill_d;
    logic [NCORES-1:0]   fin_q, fin_d, win_vec;
    logic                win_any, all_rdy, all_fin;
    logic [KEY_W-1:0]    win_key, key_q, key_d;
    logic [31:0]         cycles_q, cycles_d;
    logic                busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [7*NDIG-1:0]   seg_q, seg_d, hex_seg;

    assign all_rdy = &cores.core_rdy;
    assign all_fin = &fin_d;

    // A core finishes on the first RUN cycle its rdy is seen high.
    always_comb begin
        fin_d   = '0;
        win_vec = '0;
        if (st_q == StRun) begin
            win_vec = cores.core_rdy & ~fin_q & cores.core_key_valid;
            fin_d   = fin_q | cores.core_rdy;
        end
    end

    // Priority encoder: scanning downward leaves the lowest-index winner.
    always_comb begin
        win_any = 1'b0;
        win_key = '0;
        for (int i = int'(NCORES) - 1; i >= 0; i--) begin
            if (win_vec[i]) begin
                win_any = 1'b1;
                win_key = cores.core_key[i*KEY_W +: KEY_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= StIdle;
            kill_q   <= 1'b1;
            fin_q    <= '0;
            key_q    <= '0;
            cycles_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            seg_q    <= {NDIG{SEG_BLANK}};
        end else begin
            st_q     <= st_d;
            kill_q   <= kill_d;
            fin_q    <= fin_d;
            key_q    <= key_d;
            cycles_q <= cycles_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            seg_q    <= seg_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle:   if (start) st_d = StCrst;
            StCrst:   st_d = abort ? StIdle : StLaunch;
            StLaunch: begin
                if (abort)        st_d = StIdle;
                else if (all_rdy) st_d = StRun;
            end
            StRun: begin
                if (abort)        st_d = StIdle;
                else if (win_any) st_d = StDone;
                else if (all_fin) st_d = StFail;
            end
            StDone, StFail: if (start) st_d = StCrst;
            default:  st_d = StIdle;
        endcase
    end

    always_comb begin
        cores.core_en    = (st_q == StLaunch && all_rdy) ? '1 : '0;
        cores.core_rst_n = !(st_q == StCrst || kill_q);
        // Cores are also held in reset for the IDLE cycle that follows an abort.
        kill_d = abort && (st_q inside {StCrst, StLaunch, StRun});
        busy_d = st_d inside {StCrst, StLaunch, StRun};
        done_d = (st_d == StDone);
        fail_d = (st_d == StFail);
        unique case (st_d)
            StLaunch, StRun: cycles_d = (&cycles_q) ? cycles_q : cycles_q + 32'd1;
            StDone, StFail:  cycles_d = cycles_q;
            default:         cycles_d = '0;
        endcase
    end

    always_comb begin
        key_d = '0;
        if (st_d == StDone) key_d = (st_q == StRun) ? win_key : key_q;
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        logic [3:0] nib;
        if (4 * g < KEY_W) begin : g_key
            assign nib = key_d[4*g +: 4];
        end else begin : g_pad
            assign nib = 4'h0;
        end
        hex7seg u_hex (
            .hex_i (nib),
            .seg_o (hex_seg[7*g +: 7])
        );
    end

    always_comb begin
        seg_d = {NDIG{SEG_BLANK}};
        if (st_d == StDone)      seg_d = hex_seg;
        else if (st_d == StFail) seg_d = {NDIG{SEG_DASH}};
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign fail   = fail_q;
    assign key    = key_q;
    assign cycles = cycles_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_crack_ctrl.sv
// Randomised search scenarios against a timeline model derived from per-core schedules.
module tb_crack_ctrl;

    localparam int NC = 2;
    localparam int KW = 24;
    localparam int ND = 6;

    // Standard active-high {g,f,e,d,c,b,a} hex patterns; the display is their inverse.
    localparam logic [6:0] SEG_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [7*ND-1:0] BLANK = {ND{7'h7F}};
    localparam logic [7*ND-1:0] DASH  = {ND{7'h3F}};

    logic clk = 1'b0;
    logic rst, start, abort;
    logic busy, done, fail;
    logic [KW-1:0]   key;
    logic [31:0]     cycles;
    logic [7*ND-1:0] seg;

    always #5 clk = ~clk;

    crack_ctrl_if #(.NCORES(NC), .KEY_W(KW)) cif ();

    crack_ctrl #(.NCORES(NC), .KEY_W(KW), .NDIG(ND)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .cores  (cif.master),
        .busy   (busy),
        .done   (done),
        .fail   (fail),
        .key    (key),
        .cycles (cycles),
        .seg    (seg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    logic            e_rst_n, e_busy, e_done, e_fail;
    logic [NC-1:0]   e_en;
    logic [KW-1:0]   e_key;
    logic [31:0]     e_cycles;
    logic [7*ND-1:0] e_seg;

    // Per-core schedule for the next search: launch-ready delay, run length, result.
    int            cw [NC];
    int            cd [NC];
    bit            cv [NC];
    logic [KW-1:0] ck [NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7*ND-1:0] seg_of(input logic [KW-1:0] k);
        logic [7*ND-1:0] r;
        for (int i = 0; i < ND; i++) r[7*i +: 7] = ~SEG_HI[k[4*i +: 4]];
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("core_rst_n", {63'd0, cif.core_rst_n}, {63'd0, e_rst_n});
            check("core_en", 64'(cif.core_en), 64'(e_en));
            check("busy", {63'd0, busy}, {63'd0, e_busy});
            check("done", {63'd0, done}, {63'd0, e_done});
            check("fail", {63'd0, fail}, {63'd0, e_fail});
            check("key", 64'(key), 64'(e_key));
            check("cycles", 64'(cycles), 64'(e_cycles));
            check("seg", 64'(seg), 64'(e_seg));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cores(input logic [NC-1:0] r, input logic [NC-1:0] v,
                               input logic [NC*KW-1:0] k);
        cif.core_rdy       = r;
        cif.core_key_valid = v;
        cif.core_key       = k;
    endtask

    task automatic exp_reset_state(input logic rstn);
        e_rst_n  = rstn;
        e_en     = '0;
        e_busy   = 1'b0;
        e_done   = 1'b0;
        e_fail   = 1'b0;
        e_key    = '0;
        e_cycles = '0;
        e_seg    = BLANK;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            start   = 1'b0;
            rst     = 1'b0;
            abort   = 1'($urandom_range(0, 1));
            e_rst_n = 1'b1;
            e_en    = '0;
        end
    endtask

    // kill: 0 = run to completion, 1 = abort during RUN, 2 = rst+start during RUN.
    task automatic run_search(input int kill, input int kill_m);
        int maxw, f, win, kill_at;
        bit any_v, fin;
        logic [NC-1:0]    r, v;
        logic [NC*KW-1:0] kk;
        maxw  = 0;
        any_v = 1'b0;
        f     = 0;
        win   = 0;
        for (int i = 0; i < NC; i++) if (cw[i] > maxw) maxw = cw[i];
        for (int i = 0; i < NC; i++) begin
            if (cv[i] && (!any_v || cd[i] < f)) begin
                any_v = 1'b1;
                f     = cd[i];
                win   = i;
            end
        end
        if (!any_v) for (int i = 0; i < NC; i++) if (cd[i] > f) f = cd[i];
        kill_at = (kill == 0) ? -1 : ((kill_m >= 0) ? kill_m : int'($urandom_range(0, f - 1)));

        step();
        start   = 1'b1;
        abort   = 1'b0;
        e_rst_n = 1'b1;
        e_en    = '0;
        // Core-reset cycle
        step();
        start    = 1'($urandom_range(0, 1));
        e_busy   = 1'b1;
        e_done   = 1'b0;
        e_fail   = 1'b0;
        e_key    = '0;
        e_cycles = '0;
        e_seg    = BLANK;
        e_rst_n  = 1'b0;
        for (int j = 0; j <= maxw; j++) begin
            step();
            start = 1'($urandom_range(0, 1));
            for (int i = 0; i < NC; i++) begin
                r[i] = (j >= cw[i]);
                kk[i*KW +: KW] = KW'($urandom);
            end
            drive_cores(r, '0, kk);
            e_rst_n  = 1'b1;
            e_cycles = 32'(j + 1);
            e_en     = (j == maxw) ? '1 : '0;
        end
        for (int m = 0; m <= f; m++) begin
            step();
            start = 1'($urandom_range(0, 1));
            abort = 1'b0;
            for (int i = 0; i < NC; i++) begin
                fin  = (m >= cd[i]);
                r[i] = fin;
                v[i] = fin & cv[i];
                kk[i*KW +: KW] = fin ? ck[i] : KW'($urandom);
            end
            drive_cores(r, v, kk);
            e_en     = '0;
            e_cycles = 32'(maxw + 2 + m);
            if (m == kill_at) begin
                if (kill == 2) begin
                    rst   = 1'b1;
                    start = 1'b1;
                end else begin
                    abort = 1'b1;
                end
                step();
                rst   = 1'b0;
                start = 1'b0;
                abort = 1'b0;
                exp_reset_state(1'b0);
                return;
            end
        end
        step();
        start    = 1'b0;
        abort    = 1'b0;
        e_busy   = 1'b0;
        e_cycles = 32'(maxw + 2 + f);
        e_rst_n  = 1'b1;
        e_en     = '0;
        if (any_v) begin
            e_done = 1'b1;
            e_fail = 1'b0;
            e_key  = ck[win];
            e_seg  = seg_of(ck[win]);
        end else begin
            e_done = 1'b0;
            e_fail = 1'b1;
            e_key  = '0;
            e_seg  = DASH;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        drive_cores('1, '0, '0);
        step();
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        exp_reset_state(1'b0);
        chk_on = 1'b1;
        #2;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_seg", 64'(seg), 64'({6{7'b1111111}}));
        idle(2);

        // Core 1 wins alone
        cw = '{0, 0}; cd = '{5, 3}; cv = '{0, 1}; ck = '{24'h123456, 24'h00A3F1};
        run_search(0, -1);
        #2;
        check("lit_key_a3f1", 64'(key), 64'h00A3F1);
        check("lit_seg_a3f1", 64'(seg), 64'({7'h40, 7'h40, 7'h08, 7'h30, 7'h0E, 7'h79}));
        check("lit_done", {63'd0, done}, 64'd1);
        idle(2);

        // Tie: lowest index wins
        cw = '{0, 0}; cd = '{2, 2}; cv = '{1, 1}; ck = '{24'h000010, 24'h800010};
        run_search(0, -1);
        #2;
        check("lit_tie_key", 64'(key), 64'h000010);
        idle(1);

        // Nobody finds a key
        cw = '{0, 0}; cd = '{3, 4}; cv = '{0, 0}; ck = '{24'h111111, 24'h222222};
        run_search(0, -1);
        #2;
        check("lit_fail", {63'd0, fail}, 64'd1);
        check("lit_fail_seg", 64'(seg), 64'({6{7'b0111111}}));
        check("lit_fail_key", 64'(key), 64'd0);
        idle(1);

        // Core 1 slow to become ready in LAUNCH
        cw = '{0, 3}; cd = '{1, 2}; cv = '{0, 1}; ck = '{24'h0, 24'hBEEF01};
        run_search(0, -1);
        #2;
        check("lit_slow_cycles", 64'(cycles), 64'd7);
        idle(1);

        // Abort 5 cycles into RUN, then relaunch
        cw = '{0, 0}; cd = '{9, 9}; cv = '{1, 1}; ck = '{24'h5, 24'h6};
        run_search(1, 5);
        #2;
        check("lit_abort_cycles", 64'(cycles), 64'd0);
        check("lit_abort_rstn", {63'd0, cif.core_rst_n}, 64'd0);
        idle(1);
        cd = '{2, 1};
        run_search(0, -1);
        idle(1);

        // rst with start mid-RUN
        cd = '{9, 9};
        run_search(2, 3);
        #2;
        check("lit_rst_busy", {63'd0, busy}, 64'd0);
        check("lit_rst_key", 64'(key), 64'd0);
        idle(2);

        for (int t = 0; t < 40; t++) begin
            int sel, kind;
            for (int i = 0; i < NC; i++) begin
                cw[i] = int'($urandom_range(0, 3));
                cd[i] = int'($urandom_range(1, 8));
                cv[i] = 1'($urandom_range(0, 2) == 0);
                ck[i] = KW'($urandom);
            end
            sel  = int'($urandom_range(0, 11));
            kind = (sel < 2) ? 1 : ((sel == 2) ? 2 : 0);
            run_search(kind, -1);
            idle(int'($urandom_range(0, 3)));
        end

        step();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
